// File: rtl/gpu_pkg.sv
// Shared types and constants for the Gpu write-queue slice.
// Write record, drain FSM state encoding and Gpu command-nibble constants.
package gpu_pkg;

   localparam int GPU_ADDR_W = 12;
   localparam int GPU_DATA_W = 8;

   localparam logic [3:0] GPU_CMD_PALETTE = 4'hF;
   localparam logic [3:0] GPU_CMD_HELPER  = 4'hE;

   typedef struct packed {
      logic [GPU_ADDR_W-1:0] addr;
      logic [GPU_DATA_W-1:0] data;
   } gpu_wr_t;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      STROBE,
      HOLD
   } wq_state_t;

endpackage

// File: rtl/gpu_wq_fifo.sv
// Synchronous DEPTH-entry FIFO of gpu_wr_t records with registered full/level.
// A push while full is ignored even if a pop happens in the same cycle.
module gpu_wq_fifo
   import gpu_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  gpu_wr_t                  push_data,
   input  logic                     pop,
   output gpu_wr_t                  head,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;
   localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

   gpu_wr_t        mem [DEPTH];
   logic [PW-1:0]  wr_ptr;
   logic [PW-1:0]  rd_ptr;
   logic           push_ok;
   logic           pop_ok;
   logic [LW-1:0]  level_next;

   always_comb begin
      push_ok    = push & ~full;
      pop_ok     = pop & (level != '0);
      level_next = level + LW'(push_ok) - LW'(pop_ok);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         full   <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
         level <= level_next;
         full  <= (level_next == FULL_LEVEL);
      end
   end

   // Storage carries no reset; only the pointers define validity.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= push_data;
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/gpu_write_queue.sv
// Buffers CPU writes to the Gpu register port and drains them only during blanking,
// using a setup/strobe/hold sequence so the Gpu sees stable address/data around w.
module gpu_write_queue
   import gpu_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = GPU_ADDR_W,
   parameter int DATA_W = GPU_DATA_W
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [ADDR_W-1:0]       cpu_address,
   input  logic [DATA_W-1:0]       cpu_data,
   input  logic                    cpu_w,
   output logic                    full,
   output logic [$clog2(DEPTH):0]  level,
   output logic                    overflow,
   input  logic                    overflow_clear,
   input  logic                    blank,
   output logic [ADDR_W-1:0]       gpu_address,
   output logic [DATA_W-1:0]       gpu_data,
   output logic                    gpu_w
);

   wq_state_t state;
   wq_state_t state_next;
   logic      pop;
   gpu_wr_t   head;
   gpu_wr_t   push_data;

   assign push_data = '{addr: cpu_address, data: cpu_data};

   gpu_wq_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (cpu_w),
      .push_data (push_data),
      .pop       (pop),
      .head      (head),
      .level     (level),
      .full      (full)
   );

   // blank is only looked at when leaving IDLE or HOLD, so a transfer never aborts.
   always_comb begin
      state_next = state;
      pop        = 1'b0;
      case (state)
         IDLE, HOLD: begin
            if ((level != '0) && blank) begin
               pop        = 1'b1;
               state_next = SETUP;
            end else begin
               state_next = IDLE;
            end
         end
         SETUP:   state_next = STROBE;
         STROBE:  state_next = HOLD;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         gpu_w       <= 1'b0;
         gpu_address <= '0;
         gpu_data    <= '0;
         overflow    <= 1'b0;
      end else begin
         state <= state_next;
         gpu_w <= (state_next == STROBE);
         if (pop) begin
            gpu_address <= head.addr;
            gpu_data    <= head.data;
         end
         if (cpu_w && full)       overflow <= 1'b1;
         else if (overflow_clear) overflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_gpu_write_queue.sv
// Scoreboard bench for gpu_write_queue: a cycle-level occupancy/drain model predicts
// each transfer; a negedge monitor compares strobes, outputs and queue status.
module tb_gpu_write_queue;

   localparam int DEPTH = 16;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [11:0] cpu_address = '0;
   logic [7:0]  cpu_data = '0;
   logic        cpu_w = 1'b0;
   logic        full;
   logic [4:0]  level;
   logic        overflow;
   logic        overflow_clear = 1'b0;
   logic        blank = 1'b0;
   logic [11:0] gpu_address;
   logic [7:0]  gpu_data;
   logic        gpu_w;

   gpu_write_queue #(.DEPTH(DEPTH), .ADDR_W(12), .DATA_W(8)) dut (
      .clk            (clk),
      .reset          (reset),
      .cpu_address    (cpu_address),
      .cpu_data       (cpu_data),
      .cpu_w          (cpu_w),
      .full           (full),
      .level          (level),
      .overflow       (overflow),
      .overflow_clear (overflow_clear),
      .blank          (blank),
      .gpu_address    (gpu_address),
      .gpu_data       (gpu_data),
      .gpu_w          (gpu_w)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [11:0] addr;
      logic [7:0]  data;
      int          due;
   } xfer_t;

   int compared = 0;
   int mismatched = 0;

   // Reference model state
   int     cyc = 0;
   xfer_t  data_q[$];
   xfer_t  pend_q[$];
   int     m_cnt = 0;
   int     m_cool = 0;
   logic   m_ovf = 1'b0;
   logic [11:0] m_addr = '0;
   logic [7:0]  m_data = '0;

   task automatic check(input string name, input int act, input int exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Model: a queue drained one entry per 3 cycles whenever blank is seen at a decision point.
   always @(posedge clk) begin
      xfer_t it;
      logic  do_pop;
      logic  do_push;
      cyc++;
      if (!reset) begin
         data_q.delete();
         pend_q.delete();
         m_cnt  = 0;
         m_cool = 0;
         m_ovf  = 1'b0;
         m_addr = '0;
         m_data = '0;
      end else begin
         do_pop = 1'b0;
         if (m_cool > 0) m_cool--;
         else if (m_cnt > 0 && blank) do_pop = 1'b1;
         do_push = cpu_w && (m_cnt < DEPTH);
         if (cpu_w && m_cnt == DEPTH) m_ovf = 1'b1;
         else if (overflow_clear)     m_ovf = 1'b0;
         if (do_pop) begin
            it = data_q.pop_front();
            it.due = cyc + 1;
            pend_q.push_back(it);
            m_addr = it.addr;
            m_data = it.data;
            m_cool = 2;
         end
         if (do_push) begin
            it.addr = cpu_address;
            it.data = cpu_data;
            it.due  = 0;
            data_q.push_back(it);
         end
         m_cnt = m_cnt + int'(do_push) - int'(do_pop);
      end
   end

   // Monitor
   always @(negedge clk) begin
      xfer_t it;
      logic  exp_w;
      if (reset) begin
         exp_w = (pend_q.size() > 0) && (pend_q[0].due == cyc);
         check("gpu_w", int'(gpu_w), int'(exp_w));
         if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
            it = pend_q.pop_front();
            check("xfer_addr", int'(gpu_address), int'(it.addr));
            check("xfer_data", int'(gpu_data), int'(it.data));
         end
         check("gpu_address", int'(gpu_address), int'(m_addr));
         check("gpu_data", int'(gpu_data), int'(m_data));
         check("level", int'(level), m_cnt);
         check("full", int'(full), int'(m_cnt == DEPTH));
         check("overflow", int'(overflow), int'(m_ovf));
      end
   end

   task automatic step(input logic w, input logic [11:0] a, input logic [7:0] d,
                       input logic b, input logic clr);
      cpu_w          = w;
      cpu_address    = a;
      cpu_data       = d;
      blank          = b;
      overflow_clear = clr;
      @(posedge clk);
      #2;
   endtask

   task automatic idle(input logic b, input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0, '0, b, 1'b0);
   endtask

   task automatic rnd_push(input logic b);
      logic [11:0] a;
      a = 12'($urandom);
      if ($urandom_range(0, 3) == 0) a[11:8] = 4'hE;
      step(1'b1, a, 8'($urandom), b, 1'b0);
   endtask

   initial begin
      int waited;
      // Reset values
      #3;
      check("rst_gpu_w", int'(gpu_w), 0);
      check("rst_level", int'(level), 0);
      check("rst_full", int'(full), 0);
      check("rst_overflow", int'(overflow), 0);
      check("rst_gpu_address", int'(gpu_address), 0);
      check("rst_gpu_data", int'(gpu_data), 0);
      @(posedge clk); #2;
      @(posedge clk); #2;
      reset = 1'b1;
      idle(1'b0, 2);

      // Single write with blank high
      step(1'b1, 12'hF21, 8'h3C, 1'b1, 1'b0);
      idle(1'b1, 6);

      // Blank gating: three writes held until blank rises
      for (int i = 0; i < 3; i++) rnd_push(1'b0);
      idle(1'b0, 4);
      check("gated_level", int'(level), 3);
      idle(1'b1, 12);

      // Blank falls mid-transfer, remaining write waits
      rnd_push(1'b0);
      rnd_push(1'b0);
      idle(1'b1, 2);
      idle(1'b0, 6);
      idle(1'b1, 8);

      // Fill past capacity, clear overflow, drain
      for (int i = 0; i < 17; i++) rnd_push(1'b0);
      check("fill_full", int'(full), 1);
      check("fill_overflow", int'(overflow), 1);
      step(1'b0, '0, '0, 1'b0, 1'b1);
      check("ovf_cleared", int'(overflow), 0);
      idle(1'b1, 55);

      // Push during pops at level 5, then push while full during a pop
      for (int i = 0; i < 5; i++) rnd_push(1'b0);
      for (int i = 0; i < 9; i++) rnd_push(1'b1);
      idle(1'b1, 40);
      for (int i = 0; i < 16; i++) rnd_push(1'b0);
      rnd_push(1'b1);
      rnd_push(1'b1);
      idle(1'b1, 60);
      step(1'b0, '0, '0, 1'b1, 1'b1);

      // Randomized traffic
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 1) == 1) rnd_push(blank);
         else step(1'b0, '0, '0, blank, ($urandom_range(0, 15) == 0));
         if ($urandom_range(0, 19) == 0) blank = ~blank;
      end

      // Reset during STROBE
      for (int i = 0; i < 4; i++) rnd_push(1'b1);
      waited = 0;
      while (!gpu_w && waited < 50) begin
         step(1'b0, '0, '0, 1'b1, 1'b0);
         waited++;
      end
      check("strobe_seen", int'(gpu_w), 1);
      reset = 1'b0;
      #1;
      check("async_gpu_w", int'(gpu_w), 0);
      check("async_level", int'(level), 0);
      check("async_full", int'(full), 0);
      idle(1'b1, 3);
      reset = 1'b1;
      idle(1'b1, 12);

      // Final drain
      idle(1'b1, 80);
      check("pending_left", pend_q.size(), 0);
      check("queued_left", m_cnt, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
